serial_crc_framer: RTL and testbench

//  Byte-to-bit frame serializer placed directly upstream of serial_crc_ccitt.

---
 rtl/serial_pkg.sv | 16 +
 rtl/serial_crc_framer.sv | 141 ++++++++++++++
 tb/tb_serial_crc_framer.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial CRC framing path.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DATA,
        STALL,
        CRC,
        GAP
    } framer_state_t;

    localparam int CRC_W = 16;
    localparam logic [CRC_W-1:0] CRC_SEED = 16'hFFFF;

endpackage

// File: rtl/serial_crc_framer.sv
// Byte-to-bit frame serializer: shifts payload words out MSB-first while feeding
// an external serial CRC block, then appends that block's CRC to the line.
module serial_crc_framer #(
    parameter int DATA_W     = 8,
    parameter int CRC_W      = serial_pkg::CRC_W,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              crc_init,
    output logic              crc_enable,
    output logic              crc_data,
    input  logic [CRC_W-1:0]  crc_value,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_frame,
    output logic              underrun
);
    import serial_pkg::*;

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CW = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [CW-1:0] CRC_LAST = CW'(CRC_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    framer_state_t     state;
    framer_state_t     next_state;
    logic [DATA_W-1:0] sr;
    logic              last_q;
    logic [BW-1:0]     bit_cnt;
    logic [CW-1:0]     crc_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              stall_seen;
    logic              accept;
    logic              word_end;

    assign accept   = in_valid & in_ready;
    assign word_end = (state == DATA) && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = INIT;
            INIT:    next_state = DATA;
            DATA: begin
                if (word_end) begin
                    if (last_q) next_state = CRC;
                    else if (!accept) next_state = STALL;
                end
            end
            STALL:   if (accept) next_state = DATA;
            CRC: begin
                if (crc_cnt == CRC_LAST) next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP:     if (gap_cnt == GAP_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counters restart on any state change; bit_cnt also wraps on an in-place word reload.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr         <= '0;
            last_q     <= 1'b0;
            bit_cnt    <= '0;
            crc_cnt    <= '0;
            gap_cnt    <= '0;
            stall_seen <= 1'b0;
        end else begin
            stall_seen <= (state == STALL);
            if (accept) begin
                sr     <= in_data;
                last_q <= in_last;
            end else if (state == DATA) begin
                sr <= sr << 1;
            end

            if (state != next_state || word_end) bit_cnt <= '0;
            else if (state == DATA)              bit_cnt <= bit_cnt + BW'(1);

            if (state != next_state) crc_cnt <= '0;
            else if (state == CRC)   crc_cnt <= crc_cnt + CW'(1);

            if (state != next_state) gap_cnt <= '0;
            else if (state == GAP)   gap_cnt <= gap_cnt + GW'(1);
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        crc_init   = 1'b0;
        crc_enable = 1'b0;
        crc_data   = 1'b0;
        tx_bit     = 1'b0;
        tx_valid   = 1'b0;
        tx_frame   = 1'b0;
        underrun   = 1'b0;
        unique case (state)
            IDLE: in_ready = 1'b1;
            INIT: begin
                crc_init = 1'b1;
                tx_frame = 1'b1;
            end
            DATA: begin
                tx_valid   = 1'b1;
                tx_frame   = 1'b1;
                crc_enable = 1'b1;
                crc_data   = sr[DATA_W-1];
                tx_bit     = sr[DATA_W-1];
                in_ready   = (bit_cnt == BIT_LAST) && !last_q;
            end
            STALL: begin
                in_ready = 1'b1;
                tx_frame = 1'b1;
                underrun = !stall_seen;
            end
            CRC: begin
                tx_valid = 1'b1;
                tx_frame = 1'b1;
                tx_bit   = crc_value[CRC_LAST - crc_cnt];
            end
            GAP:     ;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_crc_framer.sv
// Bench for serial_crc_framer: two instances (GAP_CYCLES=2 and 0), each paired with a
// serial CRC-CCITT stand-in, checked against a byte-level frame/CRC reference model.
module tb_serial_crc_framer;

    typedef logic [7:0] byte_q_t[$];
    typedef int int_q_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       sel = 1'b0;

    logic a_in_valid, a_in_ready, a_crc_init, a_crc_enable, a_crc_data;
    logic a_tx_bit, a_tx_valid, a_tx_frame, a_underrun;
    logic b_in_valid, b_in_ready, b_crc_init, b_crc_enable, b_crc_data;
    logic b_tx_bit, b_tx_valid, b_tx_frame, b_underrun;
    logic [15:0] crc_a = 16'hFFFF;
    logic [15:0] crc_b = 16'hFFFF;

    logic in_ready, crc_init, crc_enable, tx_bit, tx_valid, tx_frame, underrun;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    bit got_bits[$];
    int bit_cyc[$];
    bit exp_q[$];
    logic [7:0] acc_data[$];
    int acc_cyc[$];
    int n_init = 0, n_under = 0, n_stall = 0, n_bad_en = 0, n_frame = 0, n_bad_rdy = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign a_in_valid = in_valid & ~sel;
    assign b_in_valid = in_valid & sel;

    serial_crc_framer #(.DATA_W(8), .CRC_W(16), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(a_in_valid), .in_last(in_last),
        .in_ready(a_in_ready), .crc_init(a_crc_init), .crc_enable(a_crc_enable),
        .crc_data(a_crc_data), .crc_value(crc_a), .tx_bit(a_tx_bit), .tx_valid(a_tx_valid),
        .tx_frame(a_tx_frame), .underrun(a_underrun)
    );

    serial_crc_framer #(.DATA_W(8), .CRC_W(16), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(b_in_valid), .in_last(in_last),
        .in_ready(b_in_ready), .crc_init(b_crc_init), .crc_enable(b_crc_enable),
        .crc_data(b_crc_data), .crc_value(crc_b), .tx_bit(b_tx_bit), .tx_valid(b_tx_valid),
        .tx_frame(b_tx_frame), .underrun(b_underrun)
    );

    // Stand-ins for serial_crc_ccitt: poly 0x1021, seed 0xFFFF, one bit per enabled cycle.
    always @(posedge clk) begin
        if (a_crc_init) crc_a <= 16'hFFFF;
        else if (a_crc_enable) crc_a <= {crc_a[14:0], 1'b0} ^ ((crc_a[15] ^ a_crc_data) ? 16'h1021 : 16'h0000);
        if (b_crc_init) crc_b <= 16'hFFFF;
        else if (b_crc_enable) crc_b <= {crc_b[14:0], 1'b0} ^ ((crc_b[15] ^ b_crc_data) ? 16'h1021 : 16'h0000);
    end

    assign in_ready   = sel ? b_in_ready   : a_in_ready;
    assign crc_init   = sel ? b_crc_init   : a_crc_init;
    assign crc_enable = sel ? b_crc_enable : a_crc_enable;
    assign tx_bit     = sel ? b_tx_bit     : a_tx_bit;
    assign tx_valid   = sel ? b_tx_valid   : a_tx_valid;
    assign tx_frame   = sel ? b_tx_frame   : a_tx_frame;
    assign underrun   = sel ? b_underrun   : a_underrun;

    always @(negedge clk) begin
        if (tx_valid) begin
            got_bits.push_back(tx_bit);
            bit_cyc.push_back(cyc);
        end
        if (crc_init) n_init++;
        if (underrun) n_under++;
        if (tx_frame) n_frame++;
        if (tx_frame && !tx_valid && !crc_init) n_stall++;
        if (crc_enable && !tx_valid) n_bad_en++;
        if (in_ready && (crc_init || (tx_valid && !crc_enable))) n_bad_rdy++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: textbook byte-wise CRC-CCITT (0x1021, seed 0xFFFF, no reflection).
    function automatic logic [15:0] crc16(input byte_q_t w);
        logic [15:0] c = 16'hFFFF;
        foreach (w[i]) begin
            c = c ^ {w[i], 8'h00};
            for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic append_expected(input byte_q_t w);
        logic [15:0] c;
        logic [7:0]  v;
        foreach (w[i]) begin
            v = w[i];
            for (int b = 7; b >= 0; b--) exp_q.push_back(v[b]);
        end
        c = crc16(w);
        for (int b = 15; b >= 0; b--) exp_q.push_back(c[b]);
    endtask

    function automatic int first_diff(input int gbase, input int ebase, input int n);
        if (gbase + n > got_bits.size() || ebase + n > exp_q.size()) return -2;
        for (int i = 0; i < n; i++) if (got_bits[gbase+i] !== exp_q[ebase+i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] pack_bits(input int base, input int n);
        logic [15:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[14:0], (base + i < got_bits.size()) ? got_bits[base+i] : 1'bx};
        return v;
    endfunction

    task automatic push_word(input logic [7:0] d, input logic last);
        int t = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            @(negedge clk); #1;
            t++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL accept_timeout: in_ready=%0b required=1 for word %02h", in_ready, d);
        end else begin
            acc_data.push_back(d);
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic send_frame(input byte_q_t w, input int_q_t gaps);
        foreach (w[i]) begin
            if (gaps[i] > 0) begin
                in_valid = 1'b0;
                repeat (gaps[i]) begin
                    @(negedge clk); #1;
                end
            end
            push_word(w[i], 1'(i == w.size() - 1));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_bits(input int n);
        int t = 0;
        while (got_bits.size() < n && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        total++;
        if (got_bits.size() < n) begin
            bad++;
            $display("FAIL bit_timeout: got %0d bits required %0d", got_bits.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({a_in_ready, a_crc_init, a_crc_enable, a_crc_data, a_tx_bit, a_tx_valid, a_tx_frame, a_underrun} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_outputs_gap2: got %b required 10000000",
                     {a_in_ready, a_crc_init, a_crc_enable, a_crc_data, a_tx_bit, a_tx_valid, a_tx_frame, a_underrun});
        end
        total++;
        if ({b_in_ready, b_crc_init, b_crc_enable, b_crc_data, b_tx_bit, b_tx_valid, b_tx_frame, b_underrun} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_outputs_gap0: got %b required 10000000",
                     {b_in_ready, b_crc_init, b_crc_enable, b_crc_data, b_tx_bit, b_tx_valid, b_tx_frame, b_underrun});
        end
        reset = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_string();
        byte_q_t w;
        int_q_t  gaps;
        int gb, ab, eb, nf, nu, d;
        sel = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w.push_back(8'(8'h31 + i));
            gaps.push_back(0);
        end
        gb = got_bits.size(); ab = acc_cyc.size(); eb = exp_q.size(); nf = n_frame; nu = n_under;
        append_expected(w);
        send_frame(w, gaps);
        wait_bits(gb + 88);
        total++;
        if (bit_cyc[gb] - acc_cyc[ab] !== 2) begin
            bad++;
            $display("FAIL first_bit_latency: got %0d required 2", bit_cyc[gb] - acc_cyc[ab]);
        end
        total++;
        if (bit_cyc[gb+87] - bit_cyc[gb] !== 87) begin
            bad++;
            $display("FAIL contiguous_bits: span %0d required 87", bit_cyc[gb+87] - bit_cyc[gb]);
        end
        d = first_diff(gb, eb, 72);
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL string_payload: first bad bit index %0d required none", d);
        end
        total++;
        if (pack_bits(gb + 72, 16) !== 16'h29B1) begin
            bad++;
            $display("FAIL string_crc: got %04h required 29b1", pack_bits(gb + 72, 16));
        end
        total++;
        if (n_frame - nf !== 89) begin
            bad++;
            $display("FAIL frame_length: got %0d required 89", n_frame - nf);
        end
        total++;
        if (n_under - nu !== 0) begin
            bad++;
            $display("FAIL string_underrun: got %0d required 0", n_under - nu);
        end
    endtask

    task automatic test_single();
        byte_q_t w;
        int_q_t  gaps;
        int gb;
        logic [15:0] c;
        sel = 1'b0;
        w.push_back(8'hA5);
        gaps.push_back(0);
        c = crc16(w);
        gb = got_bits.size();
        append_expected(w);
        send_frame(w, gaps);
        wait_bits(gb + 24);
        total++;
        if (pack_bits(gb, 8) !== 16'h00A5) begin
            bad++;
            $display("FAIL single_payload: got %02h required a5", pack_bits(gb, 8));
        end
        total++;
        if (pack_bits(gb + 8, 16) !== c) begin
            bad++;
            $display("FAIL single_crc_model: got %04h required %04h", pack_bits(gb + 8, 16), c);
        end
        total++;
        if (pack_bits(gb + 8, 16) !== crc_a) begin
            bad++;
            $display("FAIL single_crc_value: got %04h required %04h", pack_bits(gb + 8, 16), crc_a);
        end
        for (int g = 0; g < 2; g++) begin
            @(negedge clk); #1;
            total++;
            if ({in_ready, crc_init, crc_enable, tx_valid, tx_frame, underrun} !== 6'b0) begin
                bad++;
                $display("FAIL gap_cycle%0d: got %b required 000000", g,
                         {in_ready, crc_init, crc_enable, tx_valid, tx_frame, underrun});
            end
        end
        @(negedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_gap: got %b required 1", in_ready);
        end
    endtask

    task automatic test_stall();
        logic [7:0] w1, w2;
        byte_q_t w;
        int gb, eb, ns, nu, ne, d;
        sel = 1'b0;
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        w.push_back(w1);
        w.push_back(w2);
        gb = got_bits.size(); eb = exp_q.size(); ns = n_stall; nu = n_under; ne = n_bad_en;
        append_expected(w);
        push_word(w1, 1'b0);
        in_valid = 1'b0;
        wait_bits(gb + 8);
        repeat (3) begin
            @(negedge clk); #1;
        end
        push_word(w2, 1'b1);
        in_valid = 1'b0;
        wait_bits(gb + 32);
        total++;
        if (n_stall - ns !== 3) begin
            bad++;
            $display("FAIL stall_cycles: got %0d required 3", n_stall - ns);
        end
        total++;
        if (n_under - nu !== 1) begin
            bad++;
            $display("FAIL underrun_pulses: got %0d required 1", n_under - nu);
        end
        total++;
        if (n_bad_en - ne !== 0) begin
            bad++;
            $display("FAIL enable_in_stall: got %0d required 0", n_bad_en - ne);
        end
        total++;
        if (bit_cyc[gb+8] - bit_cyc[gb+7] !== 4) begin
            bad++;
            $display("FAIL stall_bubble: got %0d required 4", bit_cyc[gb+8] - bit_cyc[gb+7]);
        end
        d = first_diff(gb, eb, 32);
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL stall_stream: first bad bit index %0d required none", d);
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t w;
        int_q_t  gaps;
        int gb, eb, ni, d;
        sel = 1'b0;
        gb = got_bits.size();
        push_word(8'h5A, 1'b1);
        in_valid = 1'b0;
        wait_bits(gb + 13);
        reset = 1'b0;
        @(negedge clk); #1;
        total++;
        if ({a_in_ready, a_crc_init, a_crc_enable, a_crc_data, a_tx_bit, a_tx_valid, a_tx_frame, a_underrun} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL midframe_reset: got %b required 10000000",
                     {a_in_ready, a_crc_init, a_crc_enable, a_crc_data, a_tx_bit, a_tx_valid, a_tx_frame, a_underrun});
        end
        reset = 1'b1;
        w.push_back(8'hC3);
        w.push_back(8'h3C);
        gaps.push_back(1);
        gaps.push_back(0);
        gb = got_bits.size(); eb = exp_q.size(); ni = n_init;
        append_expected(w);
        send_frame(w, gaps);
        wait_bits(gb + 32);
        total++;
        if (n_init - ni !== 1) begin
            bad++;
            $display("FAIL init_after_reset: got %0d required 1", n_init - ni);
        end
        d = first_diff(gb, eb, 32);
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL stream_after_reset: first bad bit index %0d required none", d);
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 1; s >= 0; s--) begin
            byte_q_t f1, f2;
            int_q_t  g1, g2;
            int n1, n2, gb, ab, eb, ni, d, gap_seen, gap_exp;
            repeat (3) begin
                @(negedge clk); #1;
            end
            sel = 1'(s);
            gap_exp = (s == 1) ? 0 : 2;
            n1 = $urandom_range(1, 3);
            n2 = $urandom_range(1, 3);
            for (int i = 0; i < n1; i++) begin f1.push_back(8'($urandom)); g1.push_back(0); end
            for (int i = 0; i < n2; i++) begin f2.push_back(8'($urandom)); g2.push_back(0); end
            gb = got_bits.size(); ab = acc_cyc.size(); eb = exp_q.size(); ni = n_init;
            append_expected(f1);
            append_expected(f2);
            send_frame(f1, g1);
            send_frame(f2, g2);
            wait_bits(gb + 8 * (n1 + n2) + 32);
            gap_seen = acc_cyc[ab+n1] - bit_cyc[gb + 8*n1 + 15] - 1;
            total++;
            if (gap_seen !== gap_exp) begin
                bad++;
                $display("FAIL b2b_gap_sel%0d: got %0d required %0d", s, gap_seen, gap_exp);
            end
            total++;
            if (n_init - ni !== 2) begin
                bad++;
                $display("FAIL b2b_init_sel%0d: got %0d required 2", s, n_init - ni);
            end
            d = first_diff(gb, eb, 8 * (n1 + n2) + 32);
            total++;
            if (d != -1) begin
                bad++;
                $display("FAIL b2b_stream_sel%0d: first bad bit index %0d required none", s, d);
            end
        end
        repeat (3) begin
            @(negedge clk); #1;
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        byte_q_t sent;
        int_q_t  fs, fl;
        int gb, ab, eb, nr, off, d, errs;
        sel = 1'b0;
        gb = got_bits.size(); ab = acc_data.size(); eb = exp_q.size(); nr = n_bad_rdy;
        off = 0;
        for (int f = 0; f < 6; f++) begin
            byte_q_t w;
            int_q_t  gaps;
            int len;
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                w.push_back(8'($urandom));
                gaps.push_back((i == 0) ? $urandom_range(0, 4) : $urandom_range(0, 12));
                sent.push_back(w[i]);
            end
            fs.push_back(off);
            fl.push_back(8 * len + 16);
            off += 8 * len + 16;
            append_expected(w);
            send_frame(w, gaps);
        end
        wait_bits(gb + off);
        foreach (fs[f]) begin
            d = first_diff(gb + fs[f], eb + fs[f], fl[f]);
            total++;
            if (d != -1) begin
                bad++;
                $display("FAIL random_frame%0d: first bad bit index %0d required none", f, d);
            end
        end
        total++;
        if (acc_data.size() - ab !== sent.size()) begin
            bad++;
            $display("FAIL accept_count: got %0d required %0d", acc_data.size() - ab, sent.size());
        end
        errs = 0;
        foreach (sent[i]) if (ab + i >= acc_data.size() || acc_data[ab+i] !== sent[i]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL accept_order: got %0d differing words required 0", errs);
        end
        total++;
        if (n_bad_rdy - nr !== 0) begin
            bad++;
            $display("FAIL ready_in_init_or_crc: got %0d cycles required 0", n_bad_rdy - nr);
        end
    endtask

    initial begin
        test_reset();
        test_string();
        test_single();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
